sysbus_mem_responder: RTL
=========================

Name: sysbus_mem_responder

Overview:
- Responder (memory-side) end of the Sysbus request/response protocol used by the core's fetch path.
- Accepts one request at a time: cache-line reads and cache-line writes, 8 beats of 64 bits each.
- Returns read data as an 8-beat response burst, backed by an internal word array.
- Serves as the memory model for core bring-up benches; a backdoor port preloads program images.

Parameters:
BUS_DATA_WIDTH, 64, data/address width of bus_req and bus_resp.
BUS_TAG_WIDTH, 13, tag width: bit 12 = R/W (1=READ, 0=WRITE), bits 11:8 = space (4'b0001 MEMORY, other = MMIO), bits 7:0 = id.
MEM_WORDS, 1024, depth of the backing array in 64-bit words; must be a power of 2 and ≥8.
READ_LATENCY, 4, idle cycles between request accept and the first response beat; 0 is legal.
BEATS, 8, beats per line (fixed at 8; line = 64 bytes).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
bus_reqcyc  in  1  request/write-data beat valid
bus_req  in  BUS_DATA_WIDTH  byte address on the header beat; write data on data beats
bus_reqtag  in  BUS_TAG_WIDTH  request tag, sampled on the header beat
bus_reqack  out  1  accept, combinational: header or data beat is taken in a cycle where bus_reqcyc&bus_reqack
bus_respcyc  out  1  response beat valid
bus_resp  out  BUS_DATA_WIDTH  response data
bus_resptag  out  BUS_TAG_WIDTH  latched request tag, echoed on every response beat
bus_respack  in  1  initiator accepts the current beat when bus_respcyc&bus_respack
ld_en  in  1  backdoor write enable
ld_addr  in  $clog2(MEM_WORDS)  backdoor word index
ld_data  in  BUS_DATA_WIDTH  backdoor data
busy  out  1  high in every state except IDLE

Behaviour:
- Reset:
  - State = IDLE.
  - bus_respcyc=0, bus_resp=0, bus_resptag=0, busy=0; beat and latency counters = 0.
  - Memory contents are NOT cleared.
  - Reset mid-burst aborts the transaction; no further beats are issued.
- States: IDLE, LAT, RESP, WDATA.
- IDLE:
  - bus_reqack = bus_reqcyc.
  - On accept, latch line index = bus_req[5+log2(MEM_WORDS/8):6] (bits 5:0 ignored, upper bits ignored, so addresses wrap modulo the array size), latch tag, clear beat counter.
  - If tag[12]=1: go to LAT when READ_LATENCY>0, otherwise go directly to RESP.
  - If tag[12]=0: go to WDATA.
- LAT:
  - bus_reqack=0.
  - Counter runs from 0 to READ_LATENCY-1, then RESP; the first beat becomes valid READ_LATENCY+1 cycles after the accept cycle.
- RESP:
  - bus_respcyc=1; bus_resp = mem[line*8+beat]; bus_resptag = latched tag; bus_reqack=0.
  - MMIO-space reads return 0 on every beat.
  - Beats are issued in ascending order 0..7 from the aligned line base (no critical-word-first).
  - Beat advances only on bus_respcyc&bus_respack; data and tag are held stable while respack=0, with no limit on stall length.
  - Acceptance of beat 7: bus_respcyc=0 in the next cycle, return to IDLE.
- WDATA:
  - bus_reqack = bus_reqcyc.
  - Each accepted beat writes bus_req to mem[line*8+beat] (MMIO space: discarded), beat++.
  - Gaps with bus_reqcyc=0 are allowed.
  - After beat 7 is accepted, return to IDLE.
  - Writes produce no response.
- Requests arriving while busy: bus_reqack=0, so the initiator holds the request until IDLE.
- Back-to-back: from IDLE following RESP or WDATA, a held request is accepted in the first IDLE cycle (one dead cycle minimum between transactions).
- Backdoor:
  - ld_en is honoured only in IDLE, writing mem[ld_addr]=ld_data at the clock edge; ignored in other states.
  - If ld_en and a header accept happen in the same IDLE cycle, both take effect (the header does not touch memory).
- bus_respack outside RESP is ignored.
- bus_resp and bus_resptag are registered outputs; bus_reqack is the only combinational output.

Test Plan:
- Preload mem[0..7]=64'h100..107 via backdoor; read header addr 64'h0, tag {1,4'b0001,8'h00}, respack tied 1 -> reqack in cycle 0; beats 64'h100..107 in cycles 5..12 with resptag echoed; respcyc=0 in cycle 13.
- Same read with respack toggled 1,0,1,0 -> each beat is held while respack=0, exactly 8 beats accepted, in order, no duplicates.
- Write header addr 64'h40, then data 64'hA0..A7 with a 2-cycle reqcyc gap after beat 3 -> reqack only on valid beats; subsequent read of 64'h40 returns A0..A7.
- Read at addr (MEM_WORDS*8)+64'h40 -> returns the same A0..A7 (wrap); read of addr 64'h47 returns the same line (low bits ignored).
- Second read header held during an active burst -> reqack=0 until IDLE, then accepted; reset asserted at beat 3 of a read -> respcyc=0 and busy=0 the next cycle, memory intact on re-read.
- MMIO read (tag space 4'b0011) -> 8 beats of 0; MMIO write -> 8 beats acked, memory unchanged.

Source files
------------

// File: rtl/sysbus_mem_responder.sv
// Memory-side Sysbus responder: serves one 8-beat line read or write at a time
// from an internal word array, with a backdoor port for preloading images.
//
// state   | meaning
// S_IDLE  | waiting for a header; backdoor loads honoured here only
// S_LAT   | read accepted, counting READ_LATENCY idle cycles
// S_RESP  | issuing read beats 0..7, each held until the initiator acks it
// S_WDATA | collecting write data beats 0..7
module sysbus_mem_responder #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_WORDS      = 1024,
    parameter int READ_LATENCY   = 4,
    parameter int BEATS          = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0]    bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]     bus_reqtag,
    output logic                         bus_reqack,
    output logic                         bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0]    bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]     bus_resptag,
    input  logic                         bus_respack,
    input  logic                         ld_en,
    input  logic [$clog2(MEM_WORDS)-1:0] ld_addr,
    input  logic [BUS_DATA_WIDTH-1:0]    ld_data,
    output logic                         busy
);
    localparam int AW    = $clog2(MEM_WORDS);
    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
    localparam logic [2:0]       LAST_BEAT = 3'(BEATS - 1);

    typedef enum logic [1:0] {S_IDLE, S_LAT, S_RESP, S_WDATA} state_t;

    state_t                    state_q, state_d;
    logic [AW-1:0]             base_q, base_d;
    logic [BUS_TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [2:0]                beat_q, beat_d;
    logic [LAT_W-1:0]          lat_q, lat_d;
    logic                      respcyc_q, respcyc_d;
    logic [BUS_DATA_WIDTH-1:0] resp_q, resp_d;

    logic [BUS_DATA_WIDTH-1:0] mem_q [MEM_WORDS];
    logic                      mem_we;
    logic [AW-1:0]             mem_waddr;
    logic [BUS_DATA_WIDTH-1:0] mem_wdata;

    logic [AW-1:0]             idle_base;
    logic [2:0]                beat_nxt;
    logic [AW-1:0]             rd_addr;
    logic                      rd_is_mem;
    logic [BUS_DATA_WIDTH-1:0] rd_beat;

    // Line base in words; offset bits and bits above the array wrap away.
    assign idle_base = bus_req[AW+2:3] & ~AW'(7);
    assign beat_nxt  = beat_q + 3'd1;

    // Address of the beat that will be presented after the next edge.
    assign rd_addr   = (state_q == S_IDLE) ? idle_base :
                       (state_q == S_RESP) ? (base_q | AW'(beat_nxt)) : base_q;
    assign rd_is_mem = (state_q == S_IDLE) ? (bus_reqtag[11:8] == 4'b0001)
                                           : (tag_q[11:8] == 4'b0001);
    assign rd_beat   = rd_is_mem ? mem_q[rd_addr] : '0;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        tag_d      = tag_q;
        beat_d     = beat_q;
        lat_d      = lat_q;
        respcyc_d  = respcyc_q;
        resp_d     = resp_q;
        bus_reqack = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = ld_addr;
        mem_wdata  = ld_data;
        case (state_q)
            S_IDLE: begin
                bus_reqack = bus_reqcyc;
                mem_we     = ld_en;
                if (bus_reqcyc) begin
                    base_d = idle_base;
                    tag_d  = bus_reqtag;
                    beat_d = 3'd0;
                    lat_d  = '0;
                    if (bus_reqtag[12]) begin
                        if (READ_LATENCY == 0) begin
                            state_d   = S_RESP;
                            respcyc_d = 1'b1;
                            resp_d    = rd_beat;
                        end else begin
                            state_d = S_LAT;
                        end
                    end else begin
                        state_d = S_WDATA;
                    end
                end
            end
            S_LAT: begin
                if (lat_q == LAT_LAST) begin
                    state_d   = S_RESP;
                    respcyc_d = 1'b1;
                    resp_d    = rd_beat;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            S_RESP: begin
                if (bus_respack) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d   = S_IDLE;
                        respcyc_d = 1'b0;
                    end else begin
                        beat_d = beat_nxt;
                        resp_d = rd_beat;
                    end
                end
            end
            S_WDATA: begin
                bus_reqack = bus_reqcyc;
                if (bus_reqcyc) begin
                    mem_we    = (tag_q[11:8] == 4'b0001);
                    mem_waddr = base_q | AW'(beat_q);
                    mem_wdata = bus_req;
                    beat_d    = beat_nxt;
                    if (beat_q == LAST_BEAT) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            tag_q     <= '0;
            beat_q    <= '0;
            lat_q     <= '0;
            respcyc_q <= 1'b0;
            resp_q    <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            tag_q     <= tag_d;
            beat_q    <= beat_d;
            lat_q     <= lat_d;
            respcyc_q <= respcyc_d;
            resp_q    <= resp_d;
        end
    end

    // Array contents survive reset so a preloaded image outlives a core reset.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) mem_q[mem_waddr] <= mem_wdata;
    end

    assign bus_respcyc = respcyc_q;
    assign bus_resp    = resp_q;
    assign bus_resptag = tag_q;
    assign busy        = (state_q != S_IDLE);

endmodule
